// File: rtl/lenet_mul_rr_arbiter.sv
// lenet_mul_rr_arbiter: round-robin share of one signed A_W x B_W multiplier
// between NUM_REQ requesters, two-stage pipeline, one multiply per cycle.
// Ports:
//   ap_clk, ap_rst_n          clock, async active-low reset
//   arb_en                    grant enable
//   req_valid/req_ready       per-requester request / one-hot grant
//   req_a, req_b              packed operands, requester i at [i*W +: W]
//   mul_din0/mul_din1         stage-1 operands to the shared multiplier
//   mul_dout                  combinational product from the multiplier
//   rsp_valid, rsp_p          one-hot result tag and registered product
//   busy                      stage 1 or stage 2 holds an op
module lenet_mul_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 12,
    parameter int B_W     = 6,
    parameter int P_W     = 19
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic                   arb_en,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic [A_W-1:0]         mul_din0,
    output logic [B_W-1:0]         mul_din1,
    input  logic [P_W-1:0]         mul_dout,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [P_W-1:0]         rsp_p,
    output logic                   busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW:0]   NR      = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

    logic [IW-1:0]  ptr_q, ptr_d;
    logic           vld1_q, vld1_d;
    logic [IW-1:0]  tag1_q, tag1_d;
    logic [A_W-1:0] a_q, a_d;
    logic [B_W-1:0] b_q, b_d;
    logic           vld2_q, vld2_d;
    logic [IW-1:0]  tag2_q, tag2_d;
    logic [P_W-1:0] p_q, p_d;

    logic           gnt_any;
    logic [IW-1:0]  gnt_idx;
    logic [IW:0]    scan;

    // Scan from ptr+1 upward with wrap; first valid index wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan = {1'b0, ptr_q} + (IW+1)'(k);
            if (scan >= NR) begin
                scan = scan - NR;
            end
            if (!gnt_any && arb_en && req_valid[scan[IW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan[IW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Operand registers only load on a transfer so the multiplier
    // inputs stay quiet on idle cycles.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        tag1_d = tag1_q;
        ptr_d  = ptr_q;
        vld1_d = gnt_any;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_any && (gnt_idx == IW'(i))) begin
                a_d = req_a[i*A_W +: A_W];
                b_d = req_b[i*B_W +: B_W];
            end
        end
        if (gnt_any) begin
            tag1_d = gnt_idx;
            ptr_d  = gnt_idx;
        end
        vld2_d = vld1_q;
        tag2_d = vld1_q ? tag1_q : tag2_q;
        p_d    = vld1_q ? mul_dout : p_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_q  <= PTR_RST;
            vld1_q <= 1'b0;
            tag1_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            vld2_q <= 1'b0;
            tag2_q <= '0;
            p_q    <= '0;
        end else begin
            ptr_q  <= ptr_d;
            vld1_q <= vld1_d;
            tag1_q <= tag1_d;
            a_q    <= a_d;
            b_q    <= b_d;
            vld2_q <= vld2_d;
            tag2_q <= tag2_d;
            p_q    <= p_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (vld2_q) begin
            rsp_valid[tag2_q] = 1'b1;
        end
    end

    assign mul_din0 = a_q;
    assign mul_din1 = b_q;
    assign rsp_p    = p_q;
    assign busy     = vld1_q | vld2_q;

endmodule

// File: tb/tb_lenet_mul_rr_arbiter.sv
// tb_lenet_mul_rr_arbiter: bench for lenet_mul_rr_arbiter with a behavioural
// multiplier, a round-robin reference and a result scoreboard.
`timescale 1ns/1ps
module tb_lenet_mul_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int BW = 6;
    localparam int PW = 19;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n;
    logic            arb_en;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic [AW-1:0]   mul_din0;
    logic [BW-1:0]   mul_din1;
    logic [PW-1:0]   mul_dout;
    logic [N-1:0]    rsp_valid;
    logic [PW-1:0]   rsp_p;
    logic            busy;

    logic signed [PW-1:0] prod;
    assign prod     = $signed(mul_din0) * $signed(mul_din1);
    assign mul_dout = prod;

    always #5 ap_clk = ~ap_clk;

    lenet_mul_rr_arbiter #(
        .NUM_REQ(N), .A_W(AW), .B_W(BW), .P_W(PW)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .arb_en   (arb_en),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .mul_din0 (mul_din0),
        .mul_din1 (mul_din1),
        .mul_dout (mul_dout),
        .rsp_valid(rsp_valid),
        .rsp_p    (rsp_p),
        .busy     (busy)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int            tag;
        logic [PW-1:0] p;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int                   idx;
        logic signed [AW-1:0] a;
        logic signed [BW-1:0] b;
        logic signed [PW-1:0] p;
    } vec_t;
    vec_t tbl[6];

    int                   m_ptr = N - 1;
    int                   mg;
    exp_t                 me, mq;
    logic signed [AW-1:0] ma;
    logic signed [BW-1:0] mb;
    logic signed [PW-1:0] mp;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input logic en,
                                   input int p);
        if (!en) return -1;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Reference grant + scoreboard, evaluated mid-cycle.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            m_ptr = N - 1;
            sb.delete();
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    mq = sb.pop_front();
                    chk("sb_tag", 32'(rsp_valid), 32'(1 << mq.tag));
                    chk("sb_p", 32'(rsp_p), 32'(mq.p));
                end
            end
            mg = rr_pick(req_valid, arb_en, m_ptr);
            chk("sb_ready", 32'(req_ready), (mg < 0) ? 32'd0 : 32'(1 << mg));
            if (mg >= 0) begin
                ma     = req_a[mg*AW +: AW];
                mb     = req_b[mg*BW +: BW];
                mp     = ma * mb;
                me.tag = mg;
                me.p   = mp;
                sb.push_back(me);
                m_ptr  = mg;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int    en_seq[7];
    int    rdy_seq[7];

    initial begin
        tbl[0] = '{0,  12'sd100,  -6'sd3,  -19'sd300};
        tbl[1] = '{0, -12'sd2048, -6'sd32,  19'sd65536};
        tbl[2] = '{1,  12'sd2047, -6'sd32, -19'sd65504};
        tbl[3] = '{2, -12'sd2048,  6'sd31, -19'sd63488};
        tbl[4] = '{3,  -12'sd1,   -6'sd1,   19'sd1};
        tbl[5] = '{3,   12'sd0,    6'sd17,  19'sd0};
        en_seq  = '{1, 1, 1, 0, 0, 1, 1};
        rdy_seq = '{2, 8, 2, 0, 0, 8, 2};

        ap_rst_n  = 1'b0;
        arb_en    = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        @(posedge ap_clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_v", 32'(rsp_valid), 32'd0);
        chk("rst_din0", 32'(mul_din0), 32'd0);
        chk("rst_din1", 32'(mul_din1), 32'd0);
        chk("rst_rsp_p", 32'(rsp_p), 32'd0);
        chk("en_low_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        arb_en   = 1'b1;

        // Single-op vectors through the full pipeline.
        for (int i = 0; i < 6; i++) begin
            req_a[tbl[i].idx*AW +: AW] = tbl[i].a;
            req_b[tbl[i].idx*BW +: BW] = tbl[i].b;
            req_valid = N'(1 << tbl[i].idx);
            @(negedge ap_clk);
            chk("vec_ready", 32'(req_ready), 32'(1 << tbl[i].idx));
            @(posedge ap_clk);
            #1;
            req_valid = '0;
            @(negedge ap_clk);
            chk("vec_din0", 32'(mul_din0), 32'($unsigned(tbl[i].a)));
            chk("vec_din1", 32'(mul_din1), 32'($unsigned(tbl[i].b)));
            chk("vec_busy1", 32'(busy), 32'd1);
            @(posedge ap_clk);
            #1;
            @(negedge ap_clk);
            chk("vec_rsp_v", 32'(rsp_valid), 32'(1 << tbl[i].idx));
            chk("vec_rsp_p", 32'(rsp_p), 32'($unsigned(tbl[i].p)));
            chk("vec_busy2", 32'(busy), 32'd1);
            @(posedge ap_clk);
            #1;
            @(negedge ap_clk);
            chk("vec_idle_busy", 32'(busy), 32'd0);
            chk("vec_idle_rsp", 32'(rsp_valid), 32'd0);
            chk("vec_hold_din0", 32'(mul_din0), 32'($unsigned(tbl[i].a)));
            @(posedge ap_clk);
            #1;
        end

        // All requesters valid: strict rotation, one result per cycle.
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = AW'(i + 1);
            req_b[i*BW +: BW] = BW'(2);
        end
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge ap_clk);
            chk("rot_grant", 32'(req_ready), 32'(1 << (c % N)));
            if (c >= 2) begin
                chk("rot_rsp_p", 32'(rsp_p), 32'(2 * (((c - 2) % N) + 1)));
            end
            @(posedge ap_clk);
            #1;
        end
        req_valid = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rot_drain", 32'(sb.size()), 32'd0);
        chk("rot_busy", 32'(busy), 32'd0);

        // Requesters 1 and 3 with arb_en dropped for two cycles.
        req_a[1*AW +: AW] = 12'sd5;
        req_b[1*BW +: BW] = -6'sd7;
        req_a[3*AW +: AW] = -12'sd9;
        req_b[3*BW +: BW] = 6'sd3;
        req_valid = 4'b1010;
        for (int c = 0; c < 7; c++) begin
            arb_en = en_seq[c][0];
            @(negedge ap_clk);
            chk("en_grant", 32'(req_ready), 32'(rdy_seq[c]));
            if (c == 3) begin
                chk("en_inflight_busy", 32'(busy), 32'd1);
            end
            @(posedge ap_clk);
            #1;
        end
        req_valid = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("en_drain", 32'(sb.size()), 32'd0);
        chk("en_busy_low", 32'(busy), 32'd0);

        // Reset while both stages hold ops.
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = AW'(i + 1);
            req_b[i*BW +: BW] = BW'(2);
        end
        req_valid = '1;
        @(posedge ap_clk);
        #1;
        @(posedge ap_clk);
        #3;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_v", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_din0", 32'(mul_din0), 32'd0);
        chk("mid_rst_din1", 32'(mul_din1), 32'd0);
        chk("mid_rst_rsp_p", 32'(rsp_p), 32'd0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("post_rst_first", 32'(req_ready), 32'd1);
        repeat (4) @(posedge ap_clk);
        #1;
        req_valid = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("final_drain", 32'(sb.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
